ram_arbiter: RTL and testbench

Two-requester controller for the single-port `ram` block. It serialises read and write transactions from two independent masters onto the RAM's shared `addr` / `data` / `cs` / `we` / `oe` pins, with round-robin fairness. It owns the bidirectional data bus and drives it only during write accesses. It returns read data or write completion to the requester that issued the transaction.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types for the two-requester RAM controller.
//   state_e  - controller FSM states (IDLE, ACCESS, RESP)
//   req_id_t - requester identifier, with REQ_M0 / REQ_M1 constants
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   clk, rst_n - clock, asynchronous active-low reset
//   req[1:0]   - request lines (bit 0 = m0, bit 1 = m1)
//   en         - picking allowed this cycle (controller idle)
//   gnt[1:0]   - one-hot grant, zero when en is low or nobody requests
// The last-grant register resets to m1 so m0 wins the first tie.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_q == REQ_M1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_M1;
    end else if (gnt[0]) begin
      last_q <= REQ_M0;
    end else if (gnt[1]) begin
      last_q <= REQ_M1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises reads/writes from two masters onto a single-port RAM.
//   clk, rst_n                 - clock shared with the RAM, async active-low reset
//   mN_valid/we/addr/wdata     - requester transaction (hold until mN_ready)
//   mN_ready                   - transaction accepted this cycle (IDLE only)
//   mN_rsp_valid               - one-cycle completion pulse, two cycles after accept
//   mN_rsp_rdata               - last read data captured for that requester
//   mem_addr/cs/we/oe          - RAM controls, decoded from registered state only
//   mem_data                   - RAM data bus, driven only during a write ACCESS
// Flow: IDLE (grant) -> ACCESS (RAM cycle) -> RESP (completion pulse) -> IDLE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  state_e                  state_q, state_d;
  logic [1:0]              gnt;
  logic                    idle;
  logic                    access;
  logic                    we_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  req_id_t                 owner_p1;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

  assign idle   = (state_q == IDLE);
  assign access = (state_q == ACCESS);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_valid, m0_valid}),
    .en    (idle),
    .gnt   (gnt)
  );

  assign m0_ready = gnt[0];
  assign m1_ready = gnt[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|gnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: control state, owner and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_p1 <= REQ_M0;
      we_p1    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && (|gnt)) begin
        owner_p1 <= gnt[1] ? REQ_M1 : REQ_M0;
        we_p1    <= gnt[1] ? m1_we : m0_we;
      end
      // The RAM has presented read data since the mid-cycle negedge.
      if (access && !we_p1) begin
        if (owner_p1 == REQ_M0) rdata0_q <= mem_data;
        else                    rdata1_q <= mem_data;
      end
    end
  end

  // Stage p0 -> p1: payload (qualified by state, so no reset needed)
  always_ff @(posedge clk) begin
    if (idle && (|gnt)) begin
      addr_p1  <= gnt[1] ? m1_addr  : m0_addr;
      wdata_p1 <= gnt[1] ? m1_wdata : m0_wdata;
    end
  end

  assign mem_cs   = access;
  assign mem_we   = access & we_p1;
  assign mem_oe   = access & ~we_p1;
  assign mem_addr = access ? addr_p1 : '0;
  assign mem_data = mem_we ? wdata_p1 : 'z;

  assign m0_rsp_valid = (state_q == RESP) && (owner_p1 == REQ_M0);
  assign m1_rsp_valid = (state_q == RESP) && (owner_p1 == REQ_M1);
  assign m0_rsp_rdata = rdata0_q;
  assign m1_rsp_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: ram_arbiter with a behavioural single-port RAM, directed
// scenarios plus randomized traffic checked against a transaction-level model.
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_valid, m0_we, m0_ready, m0_rsp_valid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rsp_rdata;
  logic          m1_valid, m1_we, m1_ready, m1_rsp_valid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rsp_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_valid     (m0_valid),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_ready     (m0_ready),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m1_valid     (m1_valid),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_ready     (m1_ready),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_rdata (m1_rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_oe       (mem_oe)
  );

  // Behavioural single-port RAM: write at posedge, read latched at negedge.
  logic [DW-1:0] ram_mem [0:4095];
  logic [DW-1:0] ram_q   = '0;
  logic          ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= '0;
      ram_clr <= 1'b0;
    end else if (mem_cs && mem_we) begin
      ram_mem[mem_addr] <= mem_data;
    end
  end
  always @(negedge clk) begin
    if (mem_cs && mem_oe && !mem_we) ram_q <= ram_mem[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 'z;

  // Probe driver fills the bus whenever the RAM is deselected; any
  // controller drive at that time corrupts the probe value.
  logic [DW-1:0] probe = '0;
  assign mem_data = (!mem_cs) ? probe : 'z;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference model
  txn_t          q0[$], q1[$];
  int            gap_pct = 0;
  bit   [1:0]    acc = 2'b00;
  int            m_phase = 0;     // cycles into the current transaction: 0 idle, 1 RAM cycle, 2 response
  int            m_owner = 0;
  int            m_last  = 1;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] held [2];
  logic [DW-1:0] ref_mem [4096];
  int            glog[$];

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd(input logic [AW-1:0] base);
    return mk(1'($urandom), base + AW'($urandom_range(0, 15)), DW'($urandom));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 1; held[0] = '0; held[1] = '0; acc = 2'b00;
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic drive();
    txn_t t;
    probe = DW'($urandom);
    if (acc[0]) begin m0_valid = 1'b0; acc[0] = 1'b0; end
    if (acc[1]) begin m1_valid = 1'b0; acc[1] = 1'b0; end
    if (!m0_valid && q0.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      t = q0.pop_front();
      m0_valid = 1'b1; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
    end
    if (!m1_valid && q1.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      t = q1.pop_front();
      m1_valid = 1'b1; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
    end
  endtask

  task automatic monitor();
    int         win = -1;
    logic       v0 = m0_valid && rst_n;
    logic       v1 = m1_valid && rst_n;
    logic [1:0] er = 2'b00;
    logic [1:0] ev = 2'b00;
    logic       in_acc = (m_phase == 1);
    if (m_phase == 0) begin
      if (v0 && v1)  win = (m_last == 1) ? 0 : 1;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      if (win >= 0) er[win] = 1'b1;
    end
    if (m_phase == 2) begin
      ev[m_owner] = 1'b1;
      if (!m_we) held[m_owner] = ref_mem[m_addr];
    end
    chk("m0_ready", 32'(m0_ready), 32'(er[0]));
    chk("m1_ready", 32'(m1_ready), 32'(er[1]));
    chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(ev[0]));
    chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(ev[1]));
    chk("m0_rsp_rdata", 32'(m0_rsp_rdata), 32'(held[0]));
    chk("m1_rsp_rdata", 32'(m1_rsp_rdata), 32'(held[1]));
    chk("mem_cs", 32'(mem_cs), 32'(in_acc));
    chk("mem_we", 32'(mem_we), 32'(in_acc && m_we));
    chk("mem_oe", 32'(mem_oe), 32'(in_acc && !m_we));
    chk("mem_addr", 32'(mem_addr), in_acc ? 32'(m_addr) : 32'h0);
    if (in_acc && m_we) chk("mem_data_wr", 32'(mem_data), 32'(m_wdata));
    if (!in_acc)        chk("bus_release", 32'(mem_data), 32'(probe));
    case (m_phase)
      0: if (win >= 0) begin
        m_owner = win;
        m_we    = (win == 0) ? m0_we    : m1_we;
        m_addr  = (win == 0) ? m0_addr  : m1_addr;
        m_wdata = (win == 0) ? m0_wdata : m1_wdata;
        m_last  = win;
        glog.push_back(win);
        acc[win] = 1'b1;
        m_phase  = 1;
      end
      1: begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m0_ready"}, 32'(m0_ready), 32'h0);
    chk({tag, "_m1_ready"}, 32'(m1_ready), 32'h0);
    chk({tag, "_m0_rsp_valid"}, 32'(m0_rsp_valid), 32'h0);
    chk({tag, "_m1_rsp_valid"}, 32'(m1_rsp_valid), 32'h0);
    chk({tag, "_m0_rsp_rdata"}, 32'(m0_rsp_rdata), 32'h0);
    chk({tag, "_m1_rsp_rdata"}, 32'(m1_rsp_rdata), 32'h0);
    chk({tag, "_mem_ctl"}, 32'({mem_cs, mem_we, mem_oe}), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_bus_z"}, 32'(mem_data), 32'(probe));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("rst");
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m0_valid || m1_valid || m_phase != 0) && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < max), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    model_reset();

    // Power-on reset and idle
    repeat (3) cycle();
    reset_checks("por");
    rst_n = 1'b1;
    repeat (3) cycle();

    // m0 write then read
    q0.push_back(mk(1'b1, 12'h123, 8'h5A));
    q0.push_back(mk(1'b0, 12'h123, 8'h00));
    drain("wr_rd_m0", 40);
    chk("m0_read_5a", 32'(m0_rsp_rdata), 32'h5A);

    // Simultaneous valid right after reset: m0 wins the first tie
    do_reset();
    glog.delete();
    q0.push_back(mk(1'b0, 12'h010, 8'h00));
    q1.push_back(mk(1'b1, 12'h020, 8'hC3));
    q1.push_back(mk(1'b0, 12'h020, 8'h00));
    drain("simul", 40);
    chk("simul_first_gnt", 32'(glog.size() > 0 ? glog[0] : -1), 32'h0);
    chk("m1_read_c3", 32'(m1_rsp_rdata), 32'hC3);

    // Sustained contention: 12 transactions alternate m0, m1
    glog.delete();
    gap_pct = 0;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(rnd(12'h200));
      q1.push_back(rnd(12'h200));
    end
    drain("contention", 100);
    chk("contention_count", 32'(glog.size()), 32'd12);
    for (int i = 0; i < glog.size(); i++) chk("contention_order", 32'(glog[i]), 32'(i % 2));

    // Reset during the ACCESS cycle of an m1 read
    q1.push_back(mk(1'b0, 12'h020, 8'h00));
    begin
      int n = 0;
      while (m_phase != 1 && n < 20) begin cycle(); n++; end
      chk("midrst_reach_access", 32'(m_phase), 32'h1);
    end
    @(posedge clk); #1;
    drive();
    #2;
    chk("midrst_in_access", 32'(mem_cs), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("midrst");
    @(negedge clk);
    monitor();
    repeat (2) cycle();
    rst_n = 1'b1;
    q1.push_back(mk(1'b0, 12'h020, 8'h00));
    drain("midrst_reread", 40);
    chk("m1_reread_c3", 32'(m1_rsp_rdata), 32'hC3);

    // Boundary addresses
    q0.push_back(mk(1'b1, 12'hFFF, 8'hFF));
    q0.push_back(mk(1'b1, 12'h000, 8'h00));
    q0.push_back(mk(1'b0, 12'hFFF, 8'h00));
    drain("bnd_a", 40);
    chk("bnd_read_fff", 32'(m0_rsp_rdata), 32'hFF);
    q0.push_back(mk(1'b0, 12'h000, 8'h00));
    drain("bnd_b", 40);
    chk("bnd_read_000", 32'(m0_rsp_rdata), 32'h00);

    // Randomized traffic with idle gaps
    gap_pct = 40;
    for (int i = 0; i < 40; i++) begin
      q0.push_back(rnd(12'h100));
      q1.push_back(rnd(12'h100));
    end
    drain("random", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
